// File: rtl/router_pkg.sv
// Shared types and helpers for the router packet transmitter.
// Header byte layout is {len[5:0], addr[1:0]}.
package router_pkg;

    localparam int ADDR_W = 2;
    localparam int LEN_W  = 6;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] ILLEGAL_ADDR = 2'b11;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LOAD,
        TX_HEADER,
        TX_PAYLOAD,
        TX_PARITY,
        TX_GAP
    } tx_state_t;

    function automatic logic [DATA_W-1:0] pack_header(input logic [LEN_W-1:0]  len,
                                                      input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

    function automatic logic [LEN_W-1:0] header_len(input logic [DATA_W-1:0] hdr);
        return hdr[DATA_W-1:ADDR_W];
    endfunction

    function automatic logic [ADDR_W-1:0] header_addr(input logic [DATA_W-1:0] hdr);
        return hdr[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload store for router_pkt_tx: synchronous write, combinational read.
// Contents are not reset; only locations written for the current packet are ever read.
module router_tx_buf
    import router_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [LEN_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [LEN_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Store-and-forward packet source for the router input protocol.
// Optional macro ROUTER_TX_ERR_INJECT_EN adds err_inject to corrupt the parity byte.
//
// state      | meaning
// TX_IDLE    | waiting for a request (req_ready=1)
// TX_LOAD    | buffering payload bytes (pl_ready=1)
// TX_HEADER  | presenting header byte, pkt_valid=1
// TX_PAYLOAD | presenting buffered payload bytes, pkt_valid=1
// TX_PARITY  | presenting parity byte, pkt_valid=0
// TX_GAP     | forced inter-packet idle
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int MAX_LEN    = 63,
    parameter int IPG_CYCLES = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [LEN_W-1:0]    req_len,
    input  logic                pl_valid,
    input  logic [DATA_W-1:0]   pl_data,
    output logic                pl_ready,
    input  logic                busy,
`ifdef ROUTER_TX_ERR_INJECT_EN
    input  logic                err_inject,
`endif
    output logic                pkt_valid,
    output logic [DATA_W-1:0]   data_out,
    output logic                tx_done,
    output logic                req_drop
);

    localparam int DEPTH = MAX_LEN + 1;
    localparam int GAP_W = 8;

    tx_state_t         state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hdr_q, hdr_d;
    logic [DATA_W-1:0] parity_q, parity_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              err_q;
    logic [LEN_W-1:0]  len_q;
    logic              legal_accept;

    logic              pkt_valid_d;
    logic [DATA_W-1:0] data_out_d;
    logic              tx_done_d;
    logic              req_drop_d;

    logic              buf_we;
    logic [DATA_W-1:0] buf_rdata;

    assign len_q        = header_len(hdr_q);
    assign req_ready    = (state_q == TX_IDLE) && !reset;
    assign pl_ready     = (state_q == TX_LOAD);
    assign legal_accept = (state_q == TX_IDLE) && req_valid && (req_addr != ILLEGAL_ADDR);

    router_tx_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clock   (clock),
        .wr_en   (buf_we),
        .wr_addr (cnt_q),
        .wr_data (pl_data),
        .rd_addr (cnt_d),
        .rd_data (buf_rdata)
    );

`ifdef ROUTER_TX_ERR_INJECT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (legal_accept) begin
            err_q <= err_inject;
        end
    end
`else
    assign err_q = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hdr_d      = hdr_q;
        parity_d   = parity_q;
        gap_d      = gap_q;
        buf_we     = 1'b0;
        tx_done_d  = 1'b0;
        req_drop_d = 1'b0;

        case (state_q)
            TX_IDLE: begin
                if (req_valid) begin
                    if (req_addr == ILLEGAL_ADDR) begin
                        req_drop_d = 1'b1;
                    end else begin
                        hdr_d    = pack_header(req_len, req_addr);
                        parity_d = pack_header(req_len, req_addr);
                        cnt_d    = '0;
                        state_d  = (req_len == '0) ? TX_HEADER : TX_LOAD;
                    end
                end
            end
            TX_LOAD: begin
                if (pl_valid) begin
                    buf_we   = 1'b1;
                    parity_d = parity_q ^ pl_data;
                    cnt_d    = cnt_q + 6'd1;
                    if (cnt_q == len_q - 6'd1) begin
                        state_d = TX_HEADER;
                    end
                end
            end
            TX_HEADER: begin
                if (!busy) begin
                    cnt_d   = '0;
                    state_d = (len_q == '0) ? TX_PARITY : TX_PAYLOAD;
                end
            end
            TX_PAYLOAD: begin
                if (!busy) begin
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == len_q - 6'd1) begin
                        state_d = TX_PARITY;
                    end
                end
            end
            TX_PARITY: begin
                if (!busy) begin
                    tx_done_d = 1'b1;
                    if (IPG_CYCLES == 0) begin
                        state_d = TX_IDLE;
                    end else begin
                        state_d = TX_GAP;
                        gap_d   = GAP_W'(IPG_CYCLES - 1);
                    end
                end
            end
            TX_GAP: begin
                if (gap_q == '0) begin
                    state_d = TX_IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_q;
        // a stalled beat therefore re-selects the same byte every cycle.
        pkt_valid_d = 1'b0;
        data_out_d  = '0;
        case (state_d)
            TX_HEADER: begin
                pkt_valid_d = 1'b1;
                data_out_d  = hdr_d;
            end
            TX_PAYLOAD: begin
                pkt_valid_d = 1'b1;
                data_out_d  = buf_rdata;
            end
            TX_PARITY: begin
                data_out_d = parity_d ^ {{(DATA_W-1){1'b0}}, err_q};
            end
            default: begin
                pkt_valid_d = 1'b0;
                data_out_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= TX_IDLE;
            cnt_q     <= '0;
            hdr_q     <= '0;
            parity_q  <= '0;
            gap_q     <= '0;
            pkt_valid <= 1'b0;
            data_out  <= '0;
            tx_done   <= 1'b0;
            req_drop  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hdr_q     <= hdr_d;
            parity_q  <= parity_d;
            gap_q     <= gap_d;
            pkt_valid <= pkt_valid_d;
            data_out  <= data_out_d;
            tx_done   <= tx_done_d;
            req_drop  <= req_drop_d;
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed self-checking bench for router_pkt_tx.
// Inputs change 2ns after the rising edge; outputs are sampled on the falling edge.
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_addr;
    logic [5:0] req_len;
    logic       pl_valid;
    logic [7:0] pl_data;
    logic       pl_ready;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_done;
    logic       req_drop;
`ifdef ROUTER_TX_ERR_INJECT_EN
    logic       err_inject;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] beat_q[$];
    logic [7:0] par_q[$];
    int         done_cnt;
    bit         pl_seen;
    bit         pv_seen;
    logic [7:0] prev_data;
    logic [7:0] pay [64];

    always #5 clock = ~clock;

    router_pkt_tx dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .pl_valid  (pl_valid),
        .pl_data   (pl_data),
        .pl_ready  (pl_ready),
        .busy      (busy),
`ifdef ROUTER_TX_ERR_INJECT_EN
        .err_inject(err_inject),
`endif
        .pkt_valid (pkt_valid),
        .data_out  (data_out),
        .tx_done   (tx_done),
        .req_drop  (req_drop)
    );

    // Beat monitor: a header/payload beat is consumed when pkt_valid && !busy;
    // the byte shown the cycle before tx_done is the parity beat.
    always @(negedge clock) begin
        if (!reset) begin
            if (pkt_valid && !busy) beat_q.push_back(data_out);
            if (tx_done) begin
                par_q.push_back(prev_data);
                done_cnt++;
            end
            if (pl_ready) pl_seen = 1'b1;
            if (pkt_valid) pv_seen = 1'b1;
        end
        prev_data = data_out;
    end

    task automatic clear_mon();
        #1;
        beat_q.delete();
        par_q.delete();
        done_cnt = 0;
        pl_seen  = 1'b0;
        pv_seen  = 1'b0;
    endtask

    task automatic send_req(input logic [1:0] a, input logic [5:0] l);
        int n;
        @(posedge clock); #2;
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!req_ready && n < 50);
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL req_accept_timeout req_ready=%b required=1", req_ready);
        end
        @(posedge clock); #2;
        req_valid = 1'b0;
    endtask

    task automatic send_payload(input int len);
        for (int i = 0; i < len; i++) begin
            int n;
            pl_valid = 1'b1;
            pl_data  = pay[i];
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!pl_ready && n < 50);
            if (!pl_ready) begin
                checks++; failures++;
                $display("FAIL pl_accept_timeout byte=%0d pl_ready=%b required=1", i, pl_ready);
            end
            @(posedge clock); #2;
        end
        pl_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!tx_done && n < 300);
        if (!tx_done) begin
            checks++; failures++;
            $display("FAIL tx_done_timeout tx_done=%b required=1", tx_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
        pl_valid = 1'b0; pl_data = '0; busy = 1'b0;
`ifdef ROUTER_TX_ERR_INJECT_EN
        err_inject = 1'b0;
`endif
        @(negedge clock);
        checks++;
        if ({req_ready, pl_ready, pkt_valid, tx_done, req_drop} !== 5'b0 || data_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got rr=%b pr=%b pv=%b td=%b rd=%b do=%h required all 0",
                     req_ready, pl_ready, pkt_valid, tx_done, req_drop, data_out);
        end
        @(posedge clock); #2;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1 || pkt_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got req_ready=%b pkt_valid=%b required 1/0", req_ready, pkt_valid);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp [4];
        exp = '{8'h0D, 8'hA1, 8'hB2, 8'hC3};
        clear_mon();
        pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
        send_req(2'd1, 6'd3);
        send_payload(3);
        wait_done();
        checks++;
        if (pkt_valid !== 1'b0 || data_out !== 8'h00 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_gap1 got pv=%b do=%h rr=%b required 0/00/0", pkt_valid, data_out, req_ready);
        end
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b0 || tx_done !== 1'b0 || data_out !== 8'h00) begin
            failures++;
            $display("FAIL basic_gap2 got rr=%b td=%b do=%h required 0/0/00", req_ready, tx_done, data_out);
        end
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_idle got req_ready=%b required 1", req_ready);
        end
        checks++;
        if (beat_q.size() !== 4) begin
            failures++;
            $display("FAIL basic_beat_count got %0d required 4", beat_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (beat_q[i] !== exp[i]) begin
                failures++;
                $display("FAIL basic_beat%0d got %h required %h", i, beat_q[i], exp[i]);
            end
        end
        checks++;
        if (par_q.size() !== 1 || par_q[0] !== 8'hDD || done_cnt !== 1) begin
            failures++;
            $display("FAIL basic_parity got %h (done=%0d) required DD (done=1)", par_q[0], done_cnt);
        end
    endtask

    task automatic test_zero_len();
        clear_mon();
        send_req(2'd2, 6'd0);
        wait_done();
        repeat (3) @(negedge clock);
        checks++;
        if (beat_q.size() !== 1 || beat_q[0] !== 8'h02) begin
            failures++;
            $display("FAIL zero_header got %h (n=%0d) required 02 (n=1)", beat_q[0], beat_q.size());
        end
        checks++;
        if (par_q[0] !== 8'h02 || done_cnt !== 1) begin
            failures++;
            $display("FAIL zero_parity got %h (done=%0d) required 02 (done=1)", par_q[0], done_cnt);
        end
        checks++;
        if (pl_seen !== 1'b0) begin
            failures++;
            $display("FAIL zero_pl_ready got seen=%b required 0", pl_seen);
        end
    endtask

    task automatic test_busy_stall();
        logic [7:0] exp [5];
        int n;
        int cnt22;
        exp = '{8'h10, 8'h11, 8'h22, 8'h33, 8'h44};
        clear_mon();
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        send_req(2'd0, 6'd4);
        send_payload(4);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(pkt_valid && data_out == 8'h11) && n < 50);
        @(posedge clock); #2;
        busy  = 1'b1;
        cnt22 = 0;
        repeat (3) begin
            @(negedge clock);
            if (pkt_valid && data_out == 8'h22) cnt22++;
            @(posedge clock);
        end
        #2;
        busy = 1'b0;
        @(negedge clock);
        if (pkt_valid && data_out == 8'h22) cnt22++;
        checks++;
        if (cnt22 !== 4) begin
            failures++;
            $display("FAIL stall_hold got %0d cycles required 4", cnt22);
        end
        @(negedge clock);
        checks++;
        if (data_out !== 8'h33 || pkt_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_next got %h pv=%b required 33 pv=1", data_out, pkt_valid);
        end
        wait_done();
        repeat (3) @(negedge clock);
        checks++;
        if (beat_q.size() + par_q.size() !== 6) begin
            failures++;
            $display("FAIL stall_total got %0d required 6", beat_q.size() + par_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (beat_q[i] !== exp[i]) begin
                failures++;
                $display("FAIL stall_beat%0d got %h required %h", i, beat_q[i], exp[i]);
            end
        end
        checks++;
        if (par_q[0] !== 8'h54) begin
            failures++;
            $display("FAIL stall_parity got %h required 54", par_q[0]);
        end
    endtask

    task automatic test_illegal_addr();
        clear_mon();
        send_req(2'd3, 6'd5);
        @(negedge clock);
        checks++;
        if (req_drop !== 1'b1 || req_ready !== 1'b1 || pkt_valid !== 1'b0) begin
            failures++;
            $display("FAIL drop_pulse got rd=%b rr=%b pv=%b required 1/1/0", req_drop, req_ready, pkt_valid);
        end
        @(negedge clock);
        checks++;
        if (req_drop !== 1'b0) begin
            failures++;
            $display("FAIL drop_single got %b required 0", req_drop);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (pv_seen !== 1'b0 || pl_seen !== 1'b0) begin
            failures++;
            $display("FAIL drop_quiet got pv_seen=%b pl_seen=%b required 0/0", pv_seen, pl_seen);
        end
        pay[0] = 8'h5A;
        send_req(2'd0, 6'd1);
        send_payload(1);
        wait_done();
        repeat (3) @(negedge clock);
        checks++;
        if (beat_q.size() !== 2 || beat_q[0] !== 8'h04 || beat_q[1] !== 8'h5A) begin
            failures++;
            $display("FAIL drop_next_beats got %h %h (n=%0d) required 04 5A (n=2)",
                     beat_q[0], beat_q[1], beat_q.size());
        end
        checks++;
        if (par_q[0] !== 8'h5E) begin
            failures++;
            $display("FAIL drop_next_parity got %h required 5E", par_q[0]);
        end
    endtask

    task automatic test_max_len_reset();
        int n;
        clear_mon();
        for (int i = 0; i < 63; i++) pay[i] = 8'(i);
        send_req(2'd1, 6'd63);
        send_payload(63);
        wait_done();
        repeat (3) @(negedge clock);
        checks++;
        if (beat_q.size() !== 64 || beat_q[0] !== 8'hFD) begin
            failures++;
            $display("FAIL max_header got %h (n=%0d) required FD (n=64)", beat_q[0], beat_q.size());
        end
        for (int i = 0; i < 63; i++) begin
            checks++;
            if (beat_q[i+1] !== 8'(i)) begin
                failures++;
                $display("FAIL max_beat%0d got %h required %h", i, beat_q[i+1], 8'(i));
            end
        end
        checks++;
        if (par_q[0] !== 8'hC2) begin
            failures++;
            $display("FAIL max_parity got %h required C2", par_q[0]);
        end
        send_req(2'd1, 6'd63);
        send_payload(63);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(pkt_valid && data_out == 8'h10) && n < 100);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (pkt_valid !== 1'b0 || data_out !== 8'h00 || req_ready !== 1'b0 || pl_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_async got pv=%b do=%h rr=%b pr=%b required 0/00/0/0",
                     pkt_valid, data_out, req_ready, pl_ready);
        end
        clear_mon();
        @(posedge clock); #2;
        reset = 1'b0;
        repeat (20) @(negedge clock);
        checks++;
        if (done_cnt !== 0 || pv_seen !== 1'b0 || data_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_abandon got done=%0d pv_seen=%b do=%h required 0/0/00",
                     done_cnt, pv_seen, data_out);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle got req_ready=%b required 1", req_ready);
        end
    endtask

`ifdef ROUTER_TX_ERR_INJECT_EN
    task automatic test_err_inject();
        clear_mon();
        pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
        err_inject = 1'b1;
        send_req(2'd1, 6'd3);
        err_inject = 1'b0;
        send_payload(3);
        wait_done();
        repeat (3) @(negedge clock);
        checks++;
        if (par_q[0] !== 8'hDC) begin
            failures++;
            $display("FAIL err_parity got %h required DC", par_q[0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_busy_stall();
        test_illegal_addr();
        test_max_len_reset();
`ifdef ROUTER_TX_ERR_INJECT_EN
        test_err_inject();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Store-and-forward packet transmitter: the source end of the router input protocol.
- Accepts a packet request (dest addr, length) plus its payload bytes, buffers the whole payload, then drives header, payload and parity byte onto the router input (pkt_valid/data_out), stalling on router busy.
- Used as the upstream feeder in the router top and as a reusable traffic source in system benches.

Parameters:
- MAX_LEN, 63, maximum payload length; buffer depth; fixed by the 6-bit length field.
- IPG_CYCLES, 2, idle cycles forced between packets (pkt_valid=0, data_out=0); 0 means no gap.

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  packet request valid
- req_ready  out  1  request accepted when req_valid&&req_ready
- req_addr  in  2  destination port 0..2; 3 is illegal
- req_len  in  6  payload length 0..63
- pl_valid  in  1  payload byte valid
- pl_data  in  8  payload byte
- pl_ready  out  1  payload byte accepted when pl_valid&&pl_ready
- busy  in  1  router stall; a beat is consumed only on an edge with busy==0
- pkt_valid  out  1  high during header and payload beats
- data_out  out  8  header / payload / parity byte
- tx_done  out  1  one-cycle pulse after the parity beat is consumed
- req_drop  out  1  one-cycle pulse when a request with addr 3 is discarded

Behaviour:
- Reset (async, active-high): state=IDLE; req_ready=0, pl_ready=0, pkt_valid=0, data_out=0, tx_done=0, req_drop=0; parity and counters cleared. Buffer contents are undefined. A partial packet is abandoned with no parity beat.
- All outputs are registered except req_ready and pl_ready, which decode the current state.
- FSM states: IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP.
- IDLE:
  - req_ready=1.
  - On accept with addr 3: pulse req_drop next cycle and stay in IDLE.
  - On legal accept: latch header={req_len,req_addr}; parity<=header; cnt<=0.
  - Next state is LOAD, or HEADER if len==0.
- LOAD:
  - pl_ready=1; each accepted byte goes to buf[cnt]; parity^=byte; cnt++.
  - Go to HEADER on the edge accepting byte len-1.
  - pl_valid low simply waits; there is no timeout.
- HEADER: pkt_valid=1, data_out=header. Hold while busy=1. On a busy==0 edge, go to PAYLOAD (idx=0), or to PARITY if len==0.
- PAYLOAD:
  - pkt_valid=1, data_out=buf[idx]. Hold while busy=1.
  - On a busy==0 edge, idx++; after idx==len-1, go to PARITY.
- PARITY:
  - pkt_valid=0, data_out=parity (XOR of header and all payload bytes). Hold while busy=1.
  - On a busy==0 edge, pulse tx_done and go to GAP, or to IDLE if IPG_CYCLES==0.
- GAP: pkt_valid=0, data_out=0 for IPG_CYCLES cycles, then IDLE. busy is ignored.
- Stall rule: busy rising while a beat is presented holds data_out/pkt_valid unchanged until the first busy==0 edge. No beat is skipped or duplicated.
- Data is never presented before it is fully buffered, so no underrun is possible on the router side.
- Request and payload handshakes never overlap: req_ready=0 outside IDLE, pl_ready=0 outside LOAD.

Optional Feature:
- Macro ROUTER_TX_ERR_INJECT_EN.
- Defined: adds input err_inject (1 bit), sampled at request accept. If set, the PARITY beat carries parity^8'h01, for negative testing of the router error flag.
- Undefined: the port is absent and parity is always correct.

Decomposition:
- Shared package router_pkg: ADDR_W=2, LEN_W=6, DATA_W=8, ILLEGAL_ADDR=2'b11, tx state enum, header pack/unpack helper function.
- One natural sub-module: router_tx_buf, a 64x8 single-write/single-read register buffer with synchronous write and combinational read.

Test Plan:
- Basic packet: addr=1, len=3, payload A1,B2,C3, busy=0.
  - Beats: 0D,A1,B2,C3 with pkt_valid=1, then parity 0D^A1^B2^C3=DD with pkt_valid=0.
  - tx_done pulses once; then 2 gap cycles.
- Zero length: addr=2, len=0.
  - Header 02 then parity 02.
  - pl_ready is never asserted.
- Busy stall: len=4; busy=1 for 3 cycles while the 2nd payload byte is presented.
  - That byte stays on data_out for 4 cycles.
  - Total beats still 6; no duplicate or lost byte.
- Illegal address: addr=3, len=5.
  - req_drop pulses; pkt_valid stays 0; FSM returns to IDLE.
  - The next legal request transmits normally.
- Max length and reset: len=63 with incrementing payload 00..3E; expect correct parity.
  - Repeat the packet, asserting reset mid-PAYLOAD.
  - Outputs go to 0 immediately and no parity beat follows.
  - With ROUTER_TX_ERR_INJECT_EN defined and err_inject=1, the parity byte has bit 0 inverted.
